// File: rtl/mem_access_ctrl.sv
// MEM-stage data access sequencer: drives an SRAM-like req/addr_ok/data_ok bus,
// stalls the pipeline while a transaction is outstanding, and formats store/load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        misaligned, accept, addr_err;
  logic        cancel, cancel_eff;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [1:0]  fmt_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  // Alignment check; unlisted op codes behave as word accesses
  always_comb begin
    misaligned = 1'b0;
    case (mem_op_i)
      3'b000, 3'b001: misaligned = 1'b0;
      3'b010, 3'b011: misaligned = addr_i[0];
      default:        misaligned = |addr_i[1:0];
    endcase
  end

  assign accept     = (state == IDLE) && mem_req_i && !flush_i && !misaligned;
  assign addr_err   = (state == IDLE) && mem_req_i && !flush_i && misaligned;
  assign adel_o     = addr_err && !mem_we_i;
  assign ades_o     = addr_err && mem_we_i;
  assign badvaddr_o = addr_i;
  assign stall_o    = accept || (state == REQ) || (state == WAIT);
  assign data_req   = (state == REQ);
  assign done_o     = (state == DONE);
  assign cancel_eff = cancel || flush_i;

  // Store data replication and byte strobes; loads drive no strobes
  always_comb begin
    fmt_wdata = wdata_i;
    fmt_wstrb = 4'b1111;
    fmt_size  = 2'b10;
    case (mem_op_i)
      3'b000, 3'b001: begin
        fmt_wdata = {4{wdata_i[7:0]}};
        fmt_wstrb = 4'(4'b0001 << addr_i[1:0]);
        fmt_size  = 2'b00;
      end
      3'b010, 3'b011: begin
        fmt_wdata = {2{wdata_i[15:0]}};
        fmt_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
        fmt_size  = 2'b01;
      end
      default: ;
    endcase
    if (!mem_we_i) fmt_wstrb = 4'b0000;
  end

  // Load lane select and extension from the captured offset
  always_comb begin
    ld_byte  = data_rdata[{off_q, 3'b000} +: 8];
    ld_half  = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_ext = data_rdata;
    case (op_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {24'h000000, ld_byte};
      3'b010:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_ext = {16'h0000, ld_half};
      default: load_ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (data_addr_ok) state_nxt = WAIT;
      WAIT: if (data_data_ok) state_nxt = cancel_eff ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured request fields, held stable for the whole bus transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      data_wstrb <= 4'h0;
      data_size  <= 2'b00;
      data_wr    <= 1'b0;
      we_q       <= 1'b0;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
    end else if (accept) begin
      data_addr  <= addr_i;
      data_wdata <= fmt_wdata;
      data_wstrb <= fmt_wstrb;
      data_size  <= fmt_size;
      data_wr    <= mem_we_i;
      we_q       <= mem_we_i;
      op_q       <= mem_op_i;
      off_q      <= addr_i[1:0];
    end
  end

  // A flushed transaction still completes on the bus but is silently dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cancel  <= 1'b0;
      rdata_o <= 32'h0;
    end else begin
      if (state == WAIT && data_data_ok) begin
        cancel <= 1'b0;
        if (!cancel_eff && !we_q) rdata_o <= load_ext;
      end else if ((state == REQ || state == WAIT) && flush_i) begin
        cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a scoreboard of expected load results.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, flush_i;
  logic [2:0]  mem_op_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, adel_o, ades_o;
  logic [31:0] rdata_o, badvaddr_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result built lane by lane
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (off >= 2'd2) ? w[31:16] : w[15:0];
    if (op == 3'b000)      return b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
    else if (op == 3'b001) return 32'(b);
    else if (op == 3'b010) return h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
    else if (op == 3'b011) return 32'(h);
    else                   return w;
  endfunction

  task automatic ref_store(input logic we, input logic [2:0] op, input logic [1:0] off,
                           input logic [31:0] wd, output logic [31:0] ew,
                           output logic [3:0] es, output logic [1:0] ez);
    if (op == 3'b000 || op == 3'b001) begin
      ew = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      es = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 : (off == 2'd2) ? 4'b0100 : 4'b1000;
      ez = 2'b00;
    end else if (op == 3'b010 || op == 3'b011) begin
      ew = {wd[15:0], wd[15:0]};
      es = off[1] ? 4'b1100 : 4'b0011;
      ez = 2'b01;
    end else begin
      ew = wd;
      es = 4'b1111;
      ez = 2'b10;
    end
    if (!we) es = 4'b0000;
  endtask

  // One aligned access; called at posedge+1 with the DUT idle. flush_at<0 means no flush.
  task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] bus_rd,
                            input int aok_d, input int dok_d, input int flush_at);
    logic [31:0] ew;
    logic [3:0]  es;
    logic [1:0]  ez;
    int req_n, wait_n, stall_n, done_n, cyc;
    bit in_wait, got_data, finished, ok_a, ok_d;
    ref_store(we, op, addr[1:0], wd, ew, es, ez);
    if (flush_at < 0) begin
      if (we) exp_q.push_back(last_rdata);
      else    exp_q.push_back(ref_load(op, addr[1:0], bus_rd));
    end
    mem_req_i = 1'b1; mem_we_i = we; mem_op_i = op; addr_i = addr; wdata_i = wd;
    req_n = 0; wait_n = 0; stall_n = 0; done_n = 0; cyc = 0;
    in_wait = 0; got_data = 0; finished = 0;
    while (!finished && cyc < 60) begin
      @(negedge clk);
      ok_a = 0; ok_d = 0;
      if (stall_o) stall_n++;
      if (data_req) begin
        check("bus_addr", data_addr, addr);
        check("bus_wr", 32'(data_wr), 32'(we));
        check("bus_size", 32'(data_size), 32'(ez));
        check("bus_wstrb", 32'(data_wstrb), 32'(es));
        if (we) check("bus_wdata", data_wdata, ew);
        ok_a = (req_n == aok_d);
        req_n++;
      end
      if (in_wait) begin
        if (wait_n == flush_at) begin flush_i = 1'b1; mem_req_i = 1'b0; end
        if (wait_n == dok_d) ok_d = 1;
        wait_n++;
      end
      data_addr_ok = ok_a;
      data_data_ok = ok_d;
      data_rdata   = ok_d ? bus_rd : 32'hDEAD_BEEF;
      if (done_o) begin
        done_n++;
        if (exp_q.size() == 0) check("sb_empty", 32'(1), 32'(0));
        else check("rdata", rdata_o, exp_q.pop_front());
        finished = 1;
      end
      if (got_data && flush_at >= 0) begin
        check("flush_nodone", 32'(done_o), 32'(0));
        check("flush_stall", 32'(stall_o), 32'(0));
        check("flush_rdata", rdata_o, last_rdata);
        finished = 1;
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
      if (data_data_ok) begin in_wait = 0; got_data = 1; end
      if (data_addr_ok) in_wait = 1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (finished) mem_req_i = 1'b0;
      cyc++;
    end
    mem_req_i = 1'b0;
    check("finished", 32'(finished), 32'(1));
    check("stall_cycles", 32'(stall_n), 32'(3 + aok_d + dok_d));
    check("done_count", 32'(done_n), (flush_at < 0) ? 32'(1) : 32'(0));
    if (flush_at < 0 && !we) last_rdata = ref_load(op, addr[1:0], bus_rd);
    @(negedge clk);
    check("post_done", 32'(done_o), 32'(0));
    check("post_stall", 32'(stall_o), 32'(0));
    @(posedge clk); #1;
  endtask

  // Misaligned request: exception flags only, never a bus request or stall
  task automatic run_misaligned(input logic we, input logic [2:0] op, input logic [31:0] addr);
    mem_req_i = 1'b1; mem_we_i = we; mem_op_i = op; addr_i = addr; wdata_i = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_adel", 32'(adel_o), 32'(!we));
      check("mis_ades", 32'(ades_o), 32'(we));
      check("mis_badva", badvaddr_o, addr);
      check("mis_stall", 32'(stall_o), 32'(0));
      check("mis_req", 32'(data_req), 32'(0));
    end
    flush_i = 1'b1; #1;
    check("flush_noexc", 32'(adel_o | ades_o), 32'(0));
    @(posedge clk); #1;
    flush_i = 1'b0; mem_req_i = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; mem_req_i = 0; mem_we_i = 0; mem_op_i = 0; addr_i = 0; wdata_i = 0;
    flush_i = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_req", 32'(data_req), 32'(0));
    check("rst_done", 32'(done_o), 32'(0));
    check("rst_bus", {data_addr[15:0], data_wdata[7:0], data_wstrb, data_size, data_wr, 3'b000},
          32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AB_CD12, 0, 0, -1);
    run_access(1'b0, 3'b011, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 0, -1);
    run_access(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0, 0, -1);
    run_access(1'b0, 3'b100, 32'h0000_2004, 32'h0, 32'h8001_7FFF, 0, 0, -1);
    run_access(1'b1, 3'b000, 32'h0000_3002, 32'h0000_005A, 32'h0, 0, 0, -1);
    run_access(1'b1, 3'b010, 32'h0000_3002, 32'h0000_1234, 32'h0, 0, 0, -1);
    run_access(1'b1, 3'b100, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 1, 0, -1);
    run_access(1'b0, 3'b001, 32'h0000_1001, 32'h0, 32'h1234_F0AA, 0, 1, -1);
    run_misaligned(1'b0, 3'b100, 32'h0000_4001);
    run_misaligned(1'b1, 3'b010, 32'h0000_4003);
    run_misaligned(1'b0, 3'b111, 32'h0000_4002);
    run_access(1'b0, 3'b100, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 4, 3, -1);
    run_access(1'b0, 3'b000, 32'h0000_7000, 32'h0, 32'h0000_0011, 0, 3, 1);

    // Reset while the request is pending on the bus
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_op_i = 3'b100; addr_i = 32'h0000_8000;
    n = 0;
    @(negedge clk);
    while (!data_req && n < 10) begin @(negedge clk); n++; end
    check("rst_reach_req", 32'(data_req), 32'(1));
    mem_req_i = 1'b0;
    rst = 1'b1; #1;
    check("midrst_req", 32'(data_req), 32'(0));
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_stall", 32'(stall_o), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0; last_rdata = 32'h0;
    @(posedge clk); #1;
    run_access(1'b0, 3'b010, 32'h0000_9002, 32'h0, 32'hFFFE_0001, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses from the MEM stage onto an SRAM-like data bus (req/addr_ok/data_ok).
- Stalls the pipeline while a transaction is outstanding.
- Detects address misalignment, generates byte strobes and replicated store data, and sign/zero-extends load data by op and byte offset.
- Sits between the MEM-stage pipeline register and the data-side bus bridge.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mem_req_i  in  1  MEM stage holds a load/store this cycle
- mem_we_i  in  1  1=store, 0=load
- mem_op_i  in  3  000 LB/SB, 001 LBU, 010 LH/SH, 011 LHU, 100 LW/SW; other codes behave as LW/SW
- addr_i  in  32  byte address
- wdata_i  in  32  store data (rt)
- flush_i  in  1  exception/flush in MEM stage
- stall_o  out  1  freeze pipeline
- done_o  out  1  one-cycle pulse: access complete, rdata_o valid
- rdata_o  out  32  extended load data (registered)
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- badvaddr_o  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  00 byte, 01 half, 10 word
- data_wstrb  out  4  byte enables
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  32  bus read data

Behaviour:
- Reset (async): state=IDLE; rdata_o=0; all registered bus fields (data_addr, data_wdata, data_wstrb, data_size, data_wr) = 0; cancel flag = 0. Consequently data_req=0 and done_o=0.
- Misaligned: op 010/011 with addr_i[0]=1, or op 100 (and default codes) with addr_i[1:0]!=00. Byte ops are never misaligned.
- Combinational outputs, asserted only in IDLE with mem_req_i=1, flush_i=0, misaligned=1:
  - adel_o when mem_we_i=0; ades_o when mem_we_i=1.
  - badvaddr_o=addr_i at all times.
  - No bus transaction is started; stall_o=0.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: on mem_req_i && !flush_i && !misaligned, capture addr, op, we, addr[1:0] and the formatted wdata/wstrb/size, then go to REQ.
  - REQ: data_req=1 and all bus fields held stable. On data_addr_ok go to WAIT. data_data_ok is ignored in REQ; the slave never returns it in the addr_ok cycle.
  - WAIT: on data_data_ok:
    - for a load, rdata_o <= extract(data_rdata); stores leave rdata_o unchanged.
    - next state is DONE, or IDLE if cancel=1.
  - DONE: done_o=1 for exactly one cycle; next state IDLE. mem_req_i is ignored in DONE.
- stall_o = (IDLE && mem_req_i && !flush_i && !misaligned) || REQ || WAIT. It is deasserted in DONE so the pipeline advances.
- Minimum latency: accept in IDLE, addr_ok in the first REQ cycle, data_ok the next cycle, DONE on the following cycle. That is 3 stall cycles, then the DONE cycle.
- Store formatting:
  - SB: wdata={4{wdata_i[7:0]}}, wstrb=0001<<addr[1:0], size=00.
  - SH: wdata={2{wdata_i[15:0]}}, wstrb=0011 (addr[1]=0) or 1100, size=01.
  - SW: wdata=wdata_i, wstrb=1111, size=10.
  - data_addr=full byte address. Loads drive wstrb=0000 and data_wr=0.
- Load extract, using captured offset o:
  - LB: sign-extend byte o. LBU: zero-extend byte o.
  - LH/LHU: half at o[1], sign- or zero-extended.
  - LW: the word unchanged.
- Flush:
  - In IDLE, flush_i blocks acceptance and suppresses adel_o/ades_o.
  - In REQ or WAIT, flush_i sets cancel. The bus transaction is never abandoned; stall_o stays high until data_ok; no done_o pulse; rdata_o is not updated.
  - cancel clears on entry to IDLE.
- Reset mid-transaction returns to IDLE immediately; the bus slave is reset by the same rst.

Test Plan:
- LB at addr 0x1003, bus returns 0x80AB_CD12, addr_ok and data_ok each 1 cycle after request -> rdata_o=0xFFFF_FF80, done_o pulses once, stall_o high for exactly 3 cycles.
- LHU at 0x2002 with rdata 0x8001_7FFF -> rdata_o=0x0000_8001. LH at 0x2000 with the same data -> 0x0000_7FFF. LW at 0x2004 -> 0x8001_7FFF.
- SB 0x5A at 0x3002 -> data_wr=1, wstrb=0100, wdata=0x5A5A_5A5A, size=00. SH 0x1234 at 0x3002 -> wstrb=1100, wdata=0x1234_1234, size=01.
- LW at 0x4001 -> adel_o=1, badvaddr_o=0x4001, data_req never asserted, stall_o=0. SH at 0x4003 -> ades_o=1.
- addr_ok delayed 4 cycles and data_ok a further 3 cycles -> data_req and all bus fields stable throughout REQ, stall_o continuously high, single done_o pulse.
- flush_i pulsed during WAIT of a load -> stall_o stays high until data_ok, no done_o, rdata_o keeps its old value, FSM returns to IDLE. Asserting rst in REQ -> data_req=0 and rdata_o=0 immediately.
